// File: rtl/ramen_pkg.sv
// ramen_pkg: stock, recipe and price tables plus FSM encoding for ramen_shop_multi.
// LOW_THRESH_PCT is only consumed when LOW_STOCK_EN is defined.
package ramen_pkg;

    localparam int RAMEN_TYPES    = 4;
    localparam int RAMEN_INGS     = 5;
    localparam int INV_BITS       = 16;
    localparam int PRICE_W        = 10;
    localparam int LOW_THRESH_PCT = 10;

    localparam int ING_NOODLE   = 0;
    localparam int ING_BROTH    = 1;
    localparam int ING_TONKOTSU = 2;
    localparam int ING_MISO     = 3;
    localparam int ING_SOY      = 4;

    typedef logic [INV_BITS-1:0] inv_t;
    typedef logic [PRICE_W-1:0]  price_t;

    localparam inv_t INIT_STOCK [RAMEN_INGS] = '{
        16'd12000, 16'd41000, 16'd9000, 16'd1000, 16'd9000
    };

    // usage by [type][portion][ingredient]; portion 1 is the large bowl
    localparam inv_t RECIPE [RAMEN_TYPES][2][RAMEN_INGS] = '{
        '{'{16'd100, 16'd300, 16'd150, 16'd0,  16'd0},
          '{16'd150, 16'd500, 16'd200, 16'd0,  16'd0}},
        '{'{16'd100, 16'd300, 16'd0,   16'd0,  16'd30},
          '{16'd150, 16'd500, 16'd0,   16'd0,  16'd50}},
        '{'{16'd100, 16'd300, 16'd0,   16'd30, 16'd0},
          '{16'd150, 16'd500, 16'd0,   16'd50, 16'd0}},
        '{'{16'd100, 16'd300, 16'd0,   16'd0,  16'd0},
          '{16'd150, 16'd500, 16'd0,   16'd0,  16'd0}}
    };

    localparam price_t PRICE [RAMEN_TYPES] = '{
        10'd200, 10'd180, 10'd200, 10'd150
    };

    typedef enum logic [2:0] {
        IDLE, LOOKUP, CHECK, REPORT, SUMMARY
    } state_t;

endpackage

// File: rtl/ramen_shop_multi_stock_check.sv
// ramen_stock_check: one ingredient lane - sufficiency compare, deduct, saturating restock.
// Low-stock flag is built only with LOW_STOCK_EN defined.
module ramen_stock_check
    import ramen_pkg::*;
#(
    parameter int              INV_W = 16,
    parameter logic [INV_W-1:0] INIT = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [INV_W-1:0] usage,
    input  logic             deduct,
    input  logic             reload,
    input  logic             restock_en,
    input  logic [INV_W-1:0] restock_amt,
    output logic             ok,
    output logic             low
);

    logic [INV_W-1:0] inv_q;
    logic [INV_W:0]   sum;

    assign ok = (inv_q >= usage);

    // deduct only happens when inv_q >= usage, so sum never underflows
    always_comb begin
        sum = {1'b0, inv_q};
        if (restock_en) sum = sum + {1'b0, restock_amt};
        if (deduct) sum = sum - {1'b0, usage};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inv_q <= INIT;
        end else if (reload) begin
            inv_q <= INIT;
        end else begin
            inv_q <= sum[INV_W] ? '1 : sum[INV_W-1:0];
        end
    end

`ifdef LOW_STOCK_EN
    localparam logic [INV_W-1:0] THRESH =
        INV_W'(32'(INIT) * LOW_THRESH_PCT / 100);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) low <= 1'b0;
        else     low <= (inv_q < THRESH);
    end
`else
    assign low = 1'b0;
`endif

endmodule

// File: rtl/ramen_shop_multi.sv
// ramen_shop_multi: handshake order processor over NUM_ING stock lanes with day-end totals.
// Optional low-stock flags via macro LOW_STOCK_EN.
module ramen_shop_multi
    import ramen_pkg::*;
#(
    parameter int NUM_TYPE = RAMEN_TYPES,
    parameter int NUM_ING  = RAMEN_INGS,
    parameter int CNT_W    = 7,
    parameter int GAIN_W   = 15,
    parameter int INV_W    = INV_BITS
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        selling,
    input  logic                        portion,
    input  logic [$clog2(NUM_TYPE)-1:0] ramen_type,
    input  logic                        restock_valid,
    input  logic [$clog2(NUM_ING)-1:0]  restock_ing,
    input  logic [INV_W-1:0]            restock_amt,
    output logic                        out_valid_order,
    output logic                        success,
    output logic                        out_valid_tot,
    output logic [NUM_TYPE*CNT_W-1:0]   sold_num,
    output logic [GAIN_W-1:0]           total_gain,
    output logic [NUM_ING-1:0]          low_stock
);

    localparam int TYPE_W = $clog2(NUM_TYPE);
    localparam int ING_W  = $clog2(NUM_ING);

    state_t              state_q, state_d;
    logic                selling_q, portion_q, success_q;
    logic [TYPE_W-1:0]   type_q;
    logic [INV_W-1:0]    usage_q [NUM_ING];
    price_t              price_q;
    logic [CNT_W-1:0]    sold_q [NUM_TYPE];
    logic [GAIN_W-1:0]   gain_q;
    logic [GAIN_W:0]     gain_sum;
    logic [NUM_ING-1:0]  ok;
    logic                all_ok, deduct, reload;

    assign all_ok   = &ok;
    assign deduct   = (state_q == CHECK) && all_ok;
    assign reload   = (state_q == SUMMARY);
    assign gain_sum = {1'b0, gain_q} + (GAIN_W+1)'(price_q);

    for (genvar i = 0; i < NUM_ING; i++) begin : g_lane
        ramen_stock_check #(
            .INV_W (INV_W),
            .INIT  (INV_W'(INIT_STOCK[i]))
        ) u_lane (
            .clk         (clk),
            .rst         (rst),
            .usage       (usage_q[i]),
            .deduct      (deduct),
            .reload      (reload),
            .restock_en  (restock_valid && !reload &&
                          (restock_ing == ING_W'(i))),
            .restock_amt (restock_amt),
            .ok          (ok[i]),
            .low         (low_stock[i])
        );
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (in_valid) state_d = LOOKUP;
            LOOKUP:  state_d = CHECK;
            CHECK:   state_d = REPORT;
            REPORT:  state_d = selling_q ? IDLE : SUMMARY;
            SUMMARY: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign in_ready        = (state_q == IDLE);
    assign out_valid_order = (state_q == REPORT);
    assign success         = out_valid_order && success_q;
    assign out_valid_tot   = reload;
    assign total_gain      = reload ? gain_q : '0;

    always_comb begin
        sold_num = '0;
        if (reload) begin
            for (int t = 0; t < NUM_TYPE; t++) begin
                sold_num[(NUM_TYPE-1-t)*CNT_W +: CNT_W] = sold_q[t];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            selling_q <= 1'b0;
            portion_q <= 1'b0;
            type_q    <= '0;
            price_q   <= '0;
            success_q <= 1'b0;
            gain_q    <= '0;
            for (int i = 0; i < NUM_ING; i++) usage_q[i] <= '0;
            for (int t = 0; t < NUM_TYPE; t++) sold_q[t] <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && in_valid) begin
                selling_q <= selling;
                portion_q <= portion;
                type_q    <= ramen_type;
            end
            if (state_q == LOOKUP) begin
                for (int i = 0; i < NUM_ING; i++) begin
                    usage_q[i] <= INV_W'(RECIPE[type_q][portion_q][i]);
                end
                price_q <= PRICE[type_q];
            end
            if (state_q == CHECK) begin
                success_q <= all_ok;
                if (all_ok) begin
                    if (sold_q[type_q] != '1) begin
                        sold_q[type_q] <= sold_q[type_q] + 1'b1;
                    end
                    gain_q <= gain_sum[GAIN_W] ? '1 : gain_sum[GAIN_W-1:0];
                end
            end
            if (reload) begin
                gain_q <= '0;
                for (int t = 0; t < NUM_TYPE; t++) sold_q[t] <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ramen_shop_multi.sv
// tb_ramen_shop_multi: vector table, corner sequences and random days
// checked against an integer-level shop model.
module tb_ramen_shop_multi;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, selling, portion;
    logic [1:0]  ramen_type;
    logic        restock_valid;
    logic [2:0]  restock_ing;
    logic [15:0] restock_amt;
    logic        out_valid_order, success, out_valid_tot;
    logic [27:0] sold_num;
    logic [14:0] total_gain;
    logic [4:0]  low_stock;

    int n_cmp = 0;
    int n_bad = 0;

    int b_init [5] = '{12000, 41000, 9000, 1000, 9000};
    int b_use [4][2][5] = '{
        '{'{100, 300, 150, 0, 0},  '{150, 500, 200, 0, 0}},
        '{'{100, 300, 0, 0, 30},   '{150, 500, 0, 0, 50}},
        '{'{100, 300, 0, 30, 0},   '{150, 500, 0, 50, 0}},
        '{'{100, 300, 0, 0, 0},    '{150, 500, 0, 0, 0}}
    };
    int b_price [4] = '{200, 180, 200, 150};

    int m_inv [5];
    int m_sold [4];
    int m_gain;

    typedef struct {
        int          t;
        int          p;
        bit          exp_ok;
        logic [27:0] exp_sold;
        int          exp_gain;
    } vec_t;
    vec_t vecs [8];

    bit          ok;
    logic [27:0] s_got;
    logic [14:0] g_got;

    always #5 clk = ~clk;

    ramen_shop_multi dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .selling         (selling),
        .portion         (portion),
        .ramen_type      (ramen_type),
        .restock_valid   (restock_valid),
        .restock_ing     (restock_ing),
        .restock_amt     (restock_amt),
        .out_valid_order (out_valid_order),
        .success         (success),
        .out_valid_tot   (out_valid_tot),
        .sold_num        (sold_num),
        .total_gain      (total_gain),
        .low_stock       (low_stock)
    );

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic m_day_reset();
        for (int i = 0; i < 5; i++) m_inv[i] = b_init[i];
        for (int t = 0; t < 4; t++) m_sold[t] = 0;
        m_gain = 0;
    endtask

    task automatic m_order(input int t, input int p, output bit okm);
        okm = 1'b1;
        for (int i = 0; i < 5; i++) if (m_inv[i] < b_use[t][p][i]) okm = 1'b0;
        if (okm) begin
            for (int i = 0; i < 5; i++) m_inv[i] -= b_use[t][p][i];
            if (m_sold[t] < 127) m_sold[t]++;
            m_gain = (m_gain + b_price[t] > 32767) ? 32767 : m_gain + b_price[t];
        end
    endtask

    task automatic m_restock(input int ing, input int amt);
        if (ing < 5) begin
            m_inv[ing] = (m_inv[ing] + amt > 65535) ? 65535 : m_inv[ing] + amt;
        end
    endtask

    function automatic logic [27:0] m_packed();
        logic [27:0] r = '0;
        for (int t = 0; t < 4; t++) r = r + (28'(m_sold[t]) << (7 * (3 - t)));
        return r;
    endfunction

    function automatic logic [4:0] m_low();
        logic [4:0] r = '0;
        for (int i = 0; i < 5; i++) r[i] = (m_inv[i] < b_init[i] * 10 / 100);
        return r;
    endfunction

    task automatic restock(input int ing, input int amt);
        restock_valid = 1'b1;
        restock_ing   = 3'(ing);
        restock_amt   = 16'(amt);
        @(posedge clk); #1;
        restock_valid = 1'b0;
        m_restock(ing, amt);
    endtask

    // rs_when: 0 none, 1 restock during CHECK, 2 restock during SUMMARY
    task automatic run_order(input int t, input int p, input bit s,
                             input int rs_when, input int rs_ing, input int rs_amt,
                             output bit got_ok, output logic [27:0] got_sold,
                             output logic [14:0] got_gain);
        bit         exp_ok;
        int         guard;
        logic [4:0] exp_low;
        got_sold = '0;
        got_gain = '0;
        guard = 0;
        while (!in_ready && guard < 16) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("ready_before_order", in_ready, 1);
        ramen_type = 2'(t);
        portion    = (p != 0);
        selling    = s;
        in_valid   = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("busy_lookup", {in_ready, out_valid_order, out_valid_tot}, 0);
        @(posedge clk); #1;
        chk("busy_check", {in_ready, out_valid_order, out_valid_tot}, 0);
        if (rs_when == 1) begin
            restock_valid = 1'b1;
            restock_ing   = 3'(rs_ing);
            restock_amt   = 16'(rs_amt);
        end
        @(posedge clk); #1;
        restock_valid = 1'b0;
        m_order(t, p, exp_ok);
        if (rs_when == 1) m_restock(rs_ing, rs_amt);
        chk("verdict_strobe", out_valid_order, 1);
        chk("verdict_success", success, exp_ok);
        chk("ready_report", in_ready, 0);
        got_ok = success;
        @(posedge clk); #1;
        if (rs_when == 2) begin
            restock_valid = 1'b1;
            restock_ing   = 3'(rs_ing);
            restock_amt   = 16'(rs_amt);
        end
`ifdef LOW_STOCK_EN
        exp_low = m_low();
`else
        exp_low = '0;
`endif
        chk("low_stock", low_stock, exp_low);
        chk("verdict_one_shot", out_valid_order, 0);
        if (s) begin
            chk("ready_back", in_ready, 1);
            chk("no_total", {out_valid_tot, sold_num, total_gain}, 0);
        end else begin
            chk("total_strobe", out_valid_tot, 1);
            chk("total_sold", sold_num, m_packed());
            chk("total_gain", total_gain, m_gain);
            got_sold = sold_num;
            got_gain = total_gain;
            m_day_reset();
            @(posedge clk); #1;
            restock_valid = 1'b0;
            chk("ready_after_total", in_ready, 1);
            chk("total_one_shot", {out_valid_tot, sold_num, total_gain}, 0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bit exp_h;
        int verd;

        vecs[0] = '{0, 0, 1'b1, 28'h0200000, 200};
        vecs[1] = '{0, 1, 1'b1, 28'h0200000, 200};
        vecs[2] = '{1, 0, 1'b1, 28'h0004000, 180};
        vecs[3] = '{1, 1, 1'b1, 28'h0004000, 180};
        vecs[4] = '{2, 0, 1'b1, 28'h0000080, 200};
        vecs[5] = '{2, 1, 1'b1, 28'h0000080, 200};
        vecs[6] = '{3, 0, 1'b1, 28'h0000001, 150};
        vecs[7] = '{3, 1, 1'b1, 28'h0000001, 150};

        rst = 1'b1;
        in_valid = 1'b0;
        selling = 1'b1;
        portion = 1'b0;
        ramen_type = '0;
        restock_valid = 1'b0;
        restock_ing = '0;
        restock_amt = '0;
        m_day_reset();
        #12;
        chk("reset_in_ready", in_ready, 1);
        chk("reset_outputs", {out_valid_order, success, out_valid_tot,
                              sold_num, total_gain, low_stock}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        run_order(0, 0, 1'b0, 0, 0, 0, ok, s_got, g_got);
        chk("first_ok", ok, 1);
        chk("first_sold_t0", s_got[27:21], 1);
        chk("first_gain", g_got, 200);

        for (int v = 0; v < 8; v++) begin
            run_order(vecs[v].t, vecs[v].p, 1'b0, 0, 0, 0, ok, s_got, g_got);
            chk("vec_ok", ok, vecs[v].exp_ok);
            chk("vec_sold", s_got, vecs[v].exp_sold);
            chk("vec_gain", g_got, vecs[v].exp_gain);
        end

        for (int k = 0; k < 20; k++) run_order(2, 1, 1'b1, 0, 0, 0, ok, s_got, g_got);
        run_order(2, 1, 1'b0, 2, 3, 1000, ok, s_got, g_got);
        chk("miso21_fail", ok, 0);
        chk("miso_day_sold", s_got, 28'd2560);
        chk("miso_day_gain", g_got, 4000);

        for (int k = 0; k < 20; k++) run_order(2, 1, 1'b1, 0, 0, 0, ok, s_got, g_got);
        run_order(2, 1, 1'b1, 1, 3, 50, ok, s_got, g_got);
        chk("miso_restock_check_fail", ok, 0);
        run_order(2, 1, 1'b0, 0, 0, 0, ok, s_got, g_got);
        chk("miso_after_restock_ok", ok, 1);
        chk("miso_restock_sold", s_got, 28'd2688);
        chk("miso_restock_gain", g_got, 4200);

        m_order(3, 0, exp_h);
        ramen_type = 2'd3;
        portion = 1'b0;
        selling = 1'b1;
        in_valid = 1'b1;
        verd = 0;
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk); #1;
            if (k <= 4) chk("hold_ready", in_ready, (k == 4));
            if (k == 4) in_valid = 1'b0;
            if (out_valid_order) begin
                verd++;
                chk("hold_success", success, exp_h);
            end
        end
        chk("hold_one_verdict", verd, 1);

        ramen_type = 2'd1;
        portion = 1'b1;
        selling = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst_ready", in_ready, 1);
        chk("midrst_quiet", {out_valid_order, out_valid_tot}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        m_day_reset();
        verd = 0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            if (out_valid_order || out_valid_tot) verd++;
        end
        chk("midrst_no_verdict", verd, 0);
        run_order(1, 0, 1'b0, 0, 0, 0, ok, s_got, g_got);
        chk("midrst_next_sold", s_got, 28'h0004000);
        chk("midrst_next_gain", g_got, 180);

        for (int i = 0; i < 5; i++) restock(i, 65535);
        for (int k = 0; k < 230; k++) begin
            if (k % 40 == 39) for (int i = 0; i < 5; i++) restock(i, 65535);
            run_order(0, 0, (k != 229), 0, 0, 0, ok, s_got, g_got);
        end
        chk("sat_sold", s_got[27:21], 127);
        chk("sat_gain", g_got, 32767);

        for (int d = 0; d < 5; d++) begin
            int n;
            n = $urandom_range(30, 8);
            for (int k = 0; k < n; k++) begin
                int  t, p, when;
                bit  last;
                t = $urandom_range(3, 0);
                p = $urandom_range(1, 0);
                last = (k == n - 1);
                when = 0;
                if ($urandom_range(3, 0) == 0) begin
                    restock($urandom_range(7, 0), $urandom_range(2000, 0));
                end
                if ($urandom_range(4, 0) == 0) when = last ? 2 : 1;
                run_order(t, p, !last, when, $urandom_range(7, 0),
                          $urandom_range(3000, 0), ok, s_got, g_got);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
